mem_align_unit: RTL and testbench
=================================

# mem_align_unit

Parametrised memory-access alignment unit between the MEM stage and data memory. It replaces fixed word/half/byte byte-enable generation with a sequential unit that:
- generates byte enables and lane-shifted write data for any access size up to the bus width;
- reassembles and sign- or zero-extends load data;
- optionally splits a boundary-crossing misaligned access into two bus beats.

The pipeline stalls on `busy`.

## Interface
Parameters:
- `DATA_W`, 32, bus/data width in bits; 32 or 64. `NB = DATA_W/8` bytes per beat; `OW = log2(NB)`.
- `ADDR_W`, 32, byte-address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: access request.
- `req_ready` out 1: unit accepts the request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: log2 of the access bytes (0 byte, 1 half, 2 word, 3 dword).
- `req_signed` in 1: sign-extend load data.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `rsp_rdata` out DATA_W: extended load data; 0 for stores and errors.
- `rsp_err` out 1: access fault, valid with `rsp_valid`.
- `bus_valid` out 1: beat request to memory.
- `bus_ready` in 1: memory accepts the beat.
- `bus_we` out 1: beat is a write.
- `bus_addr` out ADDR_W: beat address, NB-aligned (low OW bits 0).
- `bus_be` out NB: byte enables.
- `bus_wdata` out DATA_W: lane-shifted write data.
- `bus_rdata` in DATA_W: read data, valid the cycle after a read handshake.
- `busy` out 1: asserted whenever the state is not IDLE.

## Operation
- FSM states: IDLE, B0, B1, RESP.
  - **IDLE:** on `req_valid` the unit latches all `req_*` fields and decodes the access.
    - Access is illegal if `req_size > OW`, or if it is misaligned with the macro absent. An illegal access goes to RESP.
    - Otherwise the next state is B0.
  - **B0:** drives beat 0. On handshake, the next state is B1 if the access is split, else RESP.
  - **B1:** drives beat 1 and captures beat-0 `bus_rdata` (for reads) on entry. On handshake the next state is RESP.
  - **RESP:** captures the last beat's `bus_rdata`. It pulses `rsp_valid` with the assembled result, then returns to IDLE.
- Access geometry:
  - `n = 1<<size` bytes.
  - Offset `o = addr[OW-1:0]`.
  - The access is misaligned when `addr mod n != 0`.
  - The access is split when `o + n > NB`.
- Beat 0:
  - `bus_addr = addr & ~(NB-1)`.
  - `bus_be = (((1<<n)-1) << o)[NB-1:0]`.
  - `bus_wdata = wdata << 8o`.
- Beat 1:
  - `bus_addr = beat0 addr + NB`.
  - `bus_be = ((1<<n)-1) >> (NB-o)`.
  - `bus_wdata = wdata >> 8(NB-o)`.
- Load assembly:
  - `raw = (r0 >> 8o) | (split ? r1 << 8(NB-o) : 0)`.
  - `raw` is masked to `n` bytes, then extended from bit `8n-1` when `req_signed` is set, else zero-extended.
  - For `n = NB` no extension applies.
- Bus rule: `bus_valid`, `bus_addr`, `bus_be`, `bus_we` and `bus_wdata` stay stable while `bus_valid` is high and `bus_ready` is low.
- Reset values, all outputs: 0, except `req_ready` = 1 once `reset` is high.
- Reset mid-operation: state goes to IDLE immediately, asynchronously. `bus_valid` drops and any in-flight beat is abandoned. No `rsp_valid` is issued for the aborted request.

## Timing
Request accepted in cycle T; `bus_ready` is tied high unless stated otherwise.
- Single beat: beat in T+1; `rsp_valid` in T+2.
- Split: beats in T+1 and T+2; `rsp_valid` in T+3.
- Illegal access: no beat; `rsp_valid` with `rsp_err=1` in T+1.
- Each low cycle of `bus_ready` delays the response by exactly one cycle.
- A new request can be accepted in the cycle after `rsp_valid`, because `req_ready` is high in IDLE.

## Configuration
- `MISALIGN_SPLIT_EN` defined:
  - misaligned accesses are legal;
  - an access contained in one beat uses one beat;
  - a boundary-crossing access uses two beats;
  - `rsp_err` only flags an illegal size.
- Macro absent:
  - any misaligned access is illegal (AdEL/AdES): no bus activity, `rsp_err=1`, `rsp_rdata=0`;
  - state B1 and its datapath are not built.

## Structure
- Package `mem_align_pkg` holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - the FSM state encoding;
  - the `OW` computation function.
- Sub-module `mem_be_gen`: combinational; generates beat-0/beat-1 byte enables, shift amounts, and the split and misaligned flags from (`addr` offset, `size`, `NB`).

## Test plan
All scenarios use `DATA_W=32`.
- sw, 0x1000, 0xDEADBEEF → one beat: addr 0x1000, be 1111, wdata 0xDEADBEEF; `rsp_valid` at T+2; `rsp_err` 0.
- sb, 0x1003, wdata 0x000000AB → be 1000, wdata 0xAB000000.
- lh signed, 0x2002, `bus_rdata` 0x8001_1234 → `rsp_rdata` 0xFFFF8001. lhu at the same address → 0x00008001.
- lw, 0x3001, macro on:
  - beat 0: 0x3000, be 1110; beat 1: 0x3004, be 0001;
  - rdata 0x44332211 then 0x88776655 → `rsp_rdata` 0x55443322 at T+3.
  - Macro off → no `bus_valid`; `rsp_err` 1 at T+1.
- `bus_ready` low for 3 cycles in B0 → bus outputs held stable; `rsp_valid` at T+5.
- `reset` low during B1 → `bus_valid` 0 in the same cycle, no `rsp_valid`; after release `req_ready` is 1 and the next sw completes normally.

Source files
------------

// File: rtl/mem_align_pkg.sv
// Shared encodings for the memory alignment unit: access sizes, FSM states
// and the byte-offset width helper.
package mem_align_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic int calc_ow(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_align_unit_be_gen.sv
// Combinational access geometry: byte enables, lane shift amounts and
// split/misaligned/size flags. Beat-1 outputs exist only with MISALIGN_SPLIT_EN.
module mem_be_gen #(
    parameter int NB = 4,
    parameter int OW = 2
) (
    input  logic [OW-1:0] i_off,
    input  logic [1:0]    i_size,
    output logic [NB-1:0] o_be0,
    output logic [OW+3:0] o_sh0,
`ifdef MISALIGN_SPLIT_EN
    output logic [NB-1:0] o_be1,
    output logic [OW+3:0] o_sh1,
    output logic          o_split,
`else
    output logic          o_misaligned,
`endif
    output logic          o_size_bad
);

    localparam logic [OW:0] NB_L = NB[OW:0];

    logic [2*NB-1:0] w_mask;
    logic [3:0]      w_n;

    // Double-width mask: the upper half holds the bytes spilling into beat 1.
    always_comb begin
        w_n    = 4'd1 << i_size;
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(w_n)) begin
                w_mask[i] = 1'b1;
            end
        end
        w_mask = w_mask << i_off;
    end

    assign o_be0      = w_mask[NB-1:0];
    assign o_sh0      = {1'b0, i_off, 3'b000};
    assign o_size_bad = int'(i_size) > OW;

`ifdef MISALIGN_SPLIT_EN
    assign o_be1   = w_mask[2*NB-1:NB];
    assign o_sh1   = {NB_L - {1'b0, i_off}, 3'b000};
    assign o_split = (int'(i_off) + int'(w_n)) > NB;
`else
    assign o_misaligned = (int'(i_off) & (int'(w_n) - 1)) != 0;
`endif

endmodule

// File: rtl/mem_align_unit.sv
// Memory-access alignment unit: byte enables, lane shifting, load extension.
// Define MISALIGN_SPLIT_EN to allow misaligned accesses (split into two beats).
import mem_align_pkg::*;

module mem_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                busy
);

    localparam int NB = DATA_W / 8;
    localparam int OW = calc_ow(DATA_W);

    state_t              r_state, w_state_next;
    logic                r_we, r_signed, r_err;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [OW-1:0]       w_off;
    logic [1:0]          w_size;
    logic [NB-1:0]       w_be0;
    logic [OW+3:0]       w_sh0;
    logic                w_size_bad, w_illegal;
    logic [ADDR_W-1:0]   w_base;
    logic [DATA_W-1:0]   w_raw, w_ext;
    logic [3:0]          w_nbytes;
    logic                w_sign;

    // Decode from the live request while idle, from the latched one afterwards.
    assign w_off  = (r_state == ST_IDLE) ? req_addr[OW-1:0] : r_addr[OW-1:0];
    assign w_size = (r_state == ST_IDLE) ? req_size : r_size;

`ifdef MISALIGN_SPLIT_EN
    logic [NB-1:0]     w_be1;
    logic [OW+3:0]     w_sh1;
    logic              w_split;
    logic              r_cap0;
    logic [DATA_W-1:0] r_rd0;

    mem_be_gen #(.NB(NB), .OW(OW)) u_be_gen (
        .i_off      (w_off),
        .i_size     (w_size),
        .o_be0      (w_be0),
        .o_sh0      (w_sh0),
        .o_be1      (w_be1),
        .o_sh1      (w_sh1),
        .o_split    (w_split),
        .o_size_bad (w_size_bad)
    );
    assign w_illegal = w_size_bad;
`else
    logic w_misaligned;

    mem_be_gen #(.NB(NB), .OW(OW)) u_be_gen (
        .i_off        (w_off),
        .i_size       (w_size),
        .o_be0        (w_be0),
        .o_sh0        (w_sh0),
        .o_misaligned (w_misaligned),
        .o_size_bad   (w_size_bad)
    );
    assign w_illegal = w_size_bad | w_misaligned;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
`ifdef MISALIGN_SPLIT_EN
            r_cap0   <= 1'b0;
            r_rd0    <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_we     <= req_we;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_illegal;
            end
`ifdef MISALIGN_SPLIT_EN
            // Beat-0 read data is only valid in the first cycle of B1.
            r_cap0 <= (r_state == ST_B0) && bus_ready && w_split;
            if (r_cap0) begin
                r_rd0 <= bus_rdata;
            end
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_next = w_illegal ? ST_RESP : ST_B0;
`ifdef MISALIGN_SPLIT_EN
            ST_B0:   if (bus_ready) w_state_next = w_split ? ST_B1 : ST_RESP;
            ST_B1:   if (bus_ready) w_state_next = ST_RESP;
`else
            ST_B0:   if (bus_ready) w_state_next = ST_RESP;
`endif
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_base = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};

    always_comb begin
        bus_valid = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (r_state == ST_B0) begin
            bus_valid = 1'b1;
            bus_addr  = w_base;
            bus_be    = w_be0;
            bus_wdata = r_wdata << w_sh0;
        end
`ifdef MISALIGN_SPLIT_EN
        if (r_state == ST_B1) begin
            bus_valid = 1'b1;
            bus_addr  = w_base + ADDR_W'(NB);
            bus_be    = w_be1;
            bus_wdata = r_wdata >> w_sh1;
        end
`endif
        bus_we = bus_valid & r_we;
    end

    // Load assembly: shift the lanes down, then mask and extend above byte n-1.
    always_comb begin
        w_raw = bus_rdata >> w_sh0;
`ifdef MISALIGN_SPLIT_EN
        if (w_split) begin
            w_raw = (r_rd0 >> w_sh0) | (bus_rdata << w_sh1);
        end
`endif
        w_nbytes = 4'd1 << r_size;
        w_sign   = 1'b0;
        w_ext    = w_raw;
        for (int i = 0; i < NB; i++) begin
            if (i == int'(w_nbytes) - 1) begin
                w_sign = w_raw[8*i+7];
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(w_nbytes)) begin
                w_ext[8*i +: 8] = {8{r_signed & w_sign}};
            end
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_ext : '0;
    assign req_ready = (r_state == ST_IDLE) & reset;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_align_unit.sv
// Scoreboard bench for mem_align_unit (DATA_W=32); expectations follow
// MISALIGN_SPLIT_EN when the bench is built with it.
module tb_mem_align_unit;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_valid;
    logic        bus_ready = 1'b1;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    beat_t       exp_bus[$];
    rsp_t        exp_rsp[$];
    logic [31:0] rd_q[$];

    mem_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory model: read data appears in the cycle after a read handshake.
    initial begin
        logic        hs;
        logic [31:0] nxt;
        forever begin
            @(negedge clk);
            hs  = bus_valid && bus_ready && !bus_we;
            nxt = 32'h0;
            if (hs && rd_q.size() != 0) nxt = rd_q.pop_front();
            @(posedge clk);
            #1;
            if (hs) bus_rdata = nxt;
        end
    end

    // Bus monitor: handshake beats against the queue, plus stall stability.
    initial begin
        beat_t e;
        logic        stall_prev = 1'b0;
        logic [31:0] s_addr = '0;
        logic [31:0] s_wdata = '0;
        logic [3:0]  s_be = '0;
        logic        s_we = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                chk("stall valid", {31'd0, bus_valid}, 32'd1);
                chk("stall addr", bus_addr, s_addr);
                chk("stall be", {28'd0, bus_be}, {28'd0, s_be});
                chk("stall wdata", bus_wdata, s_wdata);
                chk("stall we", {31'd0, bus_we}, {31'd0, s_we});
            end
            stall_prev = bus_valid && !bus_ready;
            s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata; s_we = bus_we;
            if (bus_valid && bus_ready) begin
                if (exp_bus.size() == 0) begin
                    chk("unexpected beat", bus_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_bus.pop_front();
                    $display("beat cyc=%0d addr=0x%08h be=%b we=%0b wdata=0x%08h",
                             cyc, bus_addr, bus_be, bus_we, bus_wdata);
                    chk("beat addr", bus_addr, e.addr);
                    chk("beat be", {28'd0, bus_be}, {28'd0, e.be});
                    chk("beat we", {31'd0, bus_we}, {31'd0, e.we});
                    if (e.we) chk("beat wdata", bus_wdata, e.wdata);
                end
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                $display("rsp  cyc=%0d rdata=0x%08h err=%0b", cyc, rsp_rdata, rsp_err);
                if (exp_rsp.size() == 0) begin
                    chk("unexpected rsp", rsp_rdata, 32'hFFFF_FFFF);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp rdata", rsp_rdata, e.rdata);
                    chk("rsp err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp cycle", cyc, e.cyc);
                end
            end
        end
    end

    function automatic void push_beat(input logic [31:0] a, input logic [3:0] be,
                                      input logic [31:0] wd, input logic we);
        beat_t b;
        b.addr = a; b.be = be; b.wdata = wd; b.we = we;
        exp_bus.push_back(b);
    endfunction

    // Drives one request for one cycle; lat < 0 means no response is expected.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int lat,
                         input logic [31:0] erd, input logic eerr);
        rsp_t r;
        @(posedge clk); #1;
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        if (lat >= 0) begin
            r.rdata = erd; r.err = eerr; r.cyc = cyc + lat;
            exp_rsp.push_back(r);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (exp_rsp.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " pending rsp"}, exp_rsp.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rsp_t r;
        int   t;

        #3;
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("post-reset req_ready", {31'd0, req_ready}, 32'd1);

        push_beat(32'h1000, 4'b1111, 32'hDEADBEEF, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        wait_done("sw");

        push_beat(32'h1000, 4'b1000, 32'hAB000000, 1'b1);
        issue(1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000AB, 2, 32'h0, 1'b0);
        wait_done("sb");

        push_beat(32'h1000, 4'b1100, 32'h12340000, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h1002, 32'h00001234, 2, 32'h0, 1'b0);
        wait_done("sh");

        push_beat(32'h2000, 4'b1100, 32'h0, 1'b0);
        rd_q.push_back(32'h8001_1234);
        issue(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 2, 32'hFFFF8001, 1'b0);
        wait_done("lh");

        push_beat(32'h2000, 4'b1100, 32'h0, 1'b0);
        rd_q.push_back(32'h8001_1234);
        issue(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 2, 32'h00008001, 1'b0);
        wait_done("lhu");

        push_beat(32'h2000, 4'b0010, 32'h0, 1'b0);
        rd_q.push_back(32'h0000_8000);
        issue(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 2, 32'hFFFFFF80, 1'b0);
        wait_done("lb");

        push_beat(32'h2000, 4'b1000, 32'h0, 1'b0);
        rd_q.push_back(32'h7F00_0000);
        issue(1'b0, 2'd0, 1'b1, 32'h2003, 32'h0, 2, 32'h0000007F, 1'b0);
        wait_done("lb pos");

        push_beat(32'h2000, 4'b1111, 32'h0, 1'b0);
        rd_q.push_back(32'h1234_5678);
        issue(1'b0, 2'd2, 1'b1, 32'h2000, 32'h0, 2, 32'h12345678, 1'b0);
        wait_done("lw");

        issue(1'b1, 2'd3, 1'b0, 32'h4000, 32'h55AA55AA, 1, 32'h0, 1'b1);
        wait_done("sd illegal");

`ifdef MISALIGN_SPLIT_EN
        push_beat(32'h3000, 4'b1110, 32'h0, 1'b0);
        push_beat(32'h3004, 4'b0001, 32'h0, 1'b0);
        rd_q.push_back(32'h44332211);
        rd_q.push_back(32'h88776655);
        issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 3, 32'h55443322, 1'b0);
        wait_done("lw split");

        push_beat(32'h1000, 4'b0110, 32'h00123400, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h1001, 32'h00001234, 2, 32'h0, 1'b0);
        wait_done("sh misaligned");
`else
        issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 1, 32'h0, 1'b1);
        wait_done("lw misaligned");

        issue(1'b1, 2'd1, 1'b0, 32'h1001, 32'h00001234, 1, 32'h0, 1'b1);
        wait_done("sh misaligned");
`endif

        // Three stalled cycles in B0.
        push_beat(32'h5004, 4'b1111, 32'hCAFEF00D, 1'b1);
        @(posedge clk); #1;
        bus_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h5004; req_wdata = 32'hCAFEF00D;
        r.rdata = 32'h0; r.err = 1'b0; r.cyc = cyc + 5;
        exp_rsp.push_back(r);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus_ready = 1'b1;
        wait_done("sw stall");

        // Reset while a request is in flight.
`ifdef MISALIGN_SPLIT_EN
        push_beat(32'h3000, 4'b1110, 32'h0, 1'b0);
        rd_q.push_back(32'h44332211);
        issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, -1, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("in B1 before reset", {31'd0, bus_valid}, 32'd1);
`else
        issue(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, -1, 32'h0, 1'b0);
        chk("in B0 before reset", {31'd0, bus_valid}, 32'd1);
`endif
        reset = 1'b0;
        #1;
        chk("reset abort bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("reset abort busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("after abort req_ready", {31'd0, req_ready}, 32'd1);
        rd_q.delete();

        push_beat(32'h6000, 4'b1111, 32'h11223344, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h6000, 32'h11223344, 2, 32'h0, 1'b0);
        wait_done("sw after reset");

        t = 0;
        repeat (3) @(posedge clk);
        chk("leftover beats", exp_bus.size(), 32'd0);
        chk("leftover rsps", exp_rsp.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
